// File: rtl/bcau_pkg.sv
// rtl/bcau_pkg.sv - shared constants and state type for the BCAU window sequencer
package bcau_pkg;

   // Pixels per window; the comp unit divides its accumulator by this value.
   localparam int BCAU_WIN_PIXELS = 80;

   // Brightness offset applied by the comp unit (kept here for reference).
   localparam int BCAU_SHIFT = 32;

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      AVG,
      EMIT
   } bcau_ctrl_state_t;

endpackage

// File: rtl/bcau_pixel_buf.sv
// rtl/bcau_pixel_buf.sv - one-window intensity buffer, sync write, comb read
//
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write index
//   wr_data  intensity to store
//   rd_addr  read index
//   rd_data  intensity at rd_addr (combinational)
// Contents are not reset; every slot is written before it is read.
module bcau_pixel_buf #(
   parameter int N_PIXELS = 80,
   parameter int AW       = $clog2(N_PIXELS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [N_PIXELS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bcau_ctrl.sv
// rtl/bcau_ctrl.sv - BCAU window sequencer: load a window, average it, replay it adjusted
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_pixel      input pixel stream
//   out_valid/out_ready/out_pixel   adjusted pixel stream
//   cu_wr_accum/cu_set_avg/cu_clr_accum/cu_intensity  controls to comp unit
//   cu_new_intensity                adjusted intensity from comp unit
//   busy                            low only in LOAD before the first pixel
//   window_done                     pulse on accept of the last output pixel
//   win_count                       windows completed (only with BCAU_CTRL_WIN_CNT_EN)
// Optional feature macro: BCAU_CTRL_WIN_CNT_EN
module bcau_ctrl
   import bcau_pkg::*;
#(
   parameter int N_PIXELS = BCAU_WIN_PIXELS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_pixel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_pixel,
   output logic       cu_wr_accum,
   output logic       cu_set_avg,
   output logic       cu_clr_accum,
   output logic [7:0] cu_intensity,
   input  logic [7:0] cu_new_intensity,
   output logic       busy,
`ifdef BCAU_CTRL_WIN_CNT_EN
   output logic [15:0] win_count,
`endif
   output logic       window_done
);

   localparam int                IDX_W    = $clog2(N_PIXELS);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_PIXELS - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

   bcau_ctrl_state_t state;
   logic [IDX_W-1:0] idx;

   // Registered state decodes; all zero in reset so every output is quiet.
   logic load_q;
   logic emit_q;
   logic clr_q;
   logic avg_q;
   logic busy_q;

   logic       in_acc;
   logic       out_acc;
   logic [7:0] rd_pixel;

   assign in_acc  = load_q && in_valid;
   assign out_acc = emit_q && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CLEAR;
         idx    <= '0;
         load_q <= 1'b0;
         emit_q <= 1'b0;
         clr_q  <= 1'b0;
         avg_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            // CLEAR with clr_q low only happens right after reset: spend one
            // cycle raising the clear strobe before moving on to LOAD.
            CLEAR: begin
               idx <= '0;
               if (clr_q) begin
                  clr_q  <= 1'b0;
                  load_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= LOAD;
               end else begin
                  clr_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            LOAD: begin
               if (in_acc) begin
                  busy_q <= 1'b1;
                  if (idx == IDX_LAST) begin
                     idx    <= '0;
                     load_q <= 1'b0;
                     avg_q  <= 1'b1;
                     state  <= AVG;
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end
            end
            AVG: begin
               avg_q  <= 1'b0;
               emit_q <= 1'b1;
               state  <= EMIT;
            end
            EMIT: begin
               if (out_acc) begin
                  if (idx == IDX_LAST) begin
                     idx    <= '0;
                     emit_q <= 1'b0;
                     clr_q  <= 1'b1;
                     state  <= CLEAR;
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

   bcau_pixel_buf #(
      .N_PIXELS (N_PIXELS),
      .AW       (IDX_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (in_acc),
      .wr_addr (idx),
      .wr_data (in_pixel),
      .rd_addr (idx),
      .rd_data (rd_pixel)
   );

   assign in_ready     = load_q;
   assign out_valid    = emit_q;
   assign cu_clr_accum = clr_q;
   assign cu_set_avg   = avg_q;
   assign busy         = busy_q;
   // Accumulate strobe must coincide with the accept, so it is not registered.
   assign cu_wr_accum  = in_acc;
   assign cu_intensity = load_q ? in_pixel : (emit_q ? rd_pixel : 8'd0);
   assign out_pixel    = emit_q ? cu_new_intensity : 8'd0;
   assign window_done  = out_acc && (idx == IDX_LAST);

`ifdef BCAU_CTRL_WIN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_count <= 16'd0;
      end else if (window_done) begin
         win_count <= win_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bcau_ctrl.sv
// tb/tb_bcau_ctrl.sv - scoreboard bench for bcau_ctrl with a behavioural comp unit
module tb_bcau_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_pixel = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_pixel;
   logic       cu_wr_accum;
   logic       cu_set_avg;
   logic       cu_clr_accum;
   logic [7:0] cu_intensity;
   logic [7:0] cu_new_intensity;
   logic       busy;
   logic       window_done;
`ifdef BCAU_CTRL_WIN_CNT_EN
   logic [15:0] win_count;
`endif

   always #5 clk = ~clk;

   bcau_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_pixel         (in_pixel),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pixel        (out_pixel),
      .cu_wr_accum      (cu_wr_accum),
      .cu_set_avg       (cu_set_avg),
      .cu_clr_accum     (cu_clr_accum),
      .cu_intensity     (cu_intensity),
      .cu_new_intensity (cu_new_intensity),
      .busy             (busy),
`ifdef BCAU_CTRL_WIN_CNT_EN
      .win_count        (win_count),
`endif
      .window_done      (window_done)
   );

   // Behavioural comp unit: accumulate, divide by 80, +32 above average else -32, saturating.
   logic [14:0] cu_acc = 15'd0;
   logic [7:0]  cu_avg = 8'd0;
   always @(posedge clk) begin
      if (cu_clr_accum) cu_acc <= 15'd0;
      else if (cu_wr_accum) cu_acc <= cu_acc + {7'd0, cu_intensity};
      if (cu_set_avg) cu_avg <= 8'(cu_acc / 15'd80);
   end
   always_comb begin
      cu_new_intensity = 8'd0;
      if (cu_intensity > cu_avg)
         cu_new_intensity = (cu_intensity > 8'd223) ? 8'd255 : cu_intensity + 8'd32;
      else
         cu_new_intensity = (cu_intensity < 8'd32) ? 8'd0 : cu_intensity - 8'd32;
   end

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];

   int wr_cnt = 0, avg_cnt = 0, done_cnt = 0, outs_this = 0, viol = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_pix = 8'd0, stall_ci = 8'd0;

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Monitor: outputs sampled on the falling edge, accepts happen on the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cu_wr_accum) begin
            wr_cnt++;
            if (!(in_valid && in_ready)) viol++;
         end
         if (cu_set_avg) avg_cnt++;
         if (out_valid && in_ready) viol++;
         if (window_done && !(out_valid && out_ready)) viol++;
         if (stall_prev && out_valid) begin
            chk("stall_out_pixel", int'(out_pixel), int'(stall_pix));
            chk("stall_cu_intensity", int'(cu_intensity), int'(stall_ci));
         end
         stall_prev = out_valid && !out_ready;
         stall_pix  = out_pixel;
         stall_ci   = cu_intensity;
         if (window_done) done_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("out_pixel", int'(out_pixel), int'(exp_q.pop_front()));
            end
            if (outs_this == 79 || window_done)
               chk("window_done", int'(window_done), int'(outs_this == 79));
            outs_this++;
         end
      end
   end

   function automatic logic [7:0] ramp_exp(input int i);
      // Ramp 0..79 averages to 39; 39 itself takes the -32 branch.
      if (i > 39) return 8'(i + 32);
      else if (i >= 32) return 8'(i - 32);
      else return 8'd0;
   endfunction

   task automatic send(input logic [7:0] p, input logic [7:0] e);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_pixel = p;
      exp_q.push_back(e);
      while (!ok && n <= 400) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else n++;
      end
      if (!ok) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // kind 0: flat value v with expected e; kind 1: ramp 0..79.
   task automatic load_window(input int kind, input logic [7:0] v, input logic [7:0] e,
                              input bit bubbles);
      wr_cnt = 0; avg_cnt = 0; done_cnt = 0; outs_this = 0; viol = 0;
      for (int i = 0; i < 80; i++) begin
         if (kind == 0) send(v, e);
         else send(8'(i), ramp_exp(i));
         if (bubbles && (i % 2 == 1) && i != 79) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic finish_window(input string tag, input int stall_at);
      int n;
      bit stalled;
      stalled = 1'b0;
      @(negedge clk);
      chk({tag, "_set_avg"}, int'(cu_set_avg), 1);
      chk({tag, "_avg_in_ready"}, int'(in_ready), 0);
      @(negedge clk);
      chk({tag, "_first_out_valid"}, int'(out_valid), 1);
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(posedge clk);
         #1;
         if (stall_at > 0 && !stalled && outs_this >= stall_at) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            stalled = 1'b1;
         end
         n++;
      end
      if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
      @(negedge clk);
      chk({tag, "_clr_after_done"}, int'(cu_clr_accum), 1);
      chk({tag, "_busy_in_clear"}, int'(busy), 1);
      chk({tag, "_wr_count"}, wr_cnt, 80);
      chk({tag, "_avg_count"}, avg_cnt, 1);
      chk({tag, "_out_count"}, outs_this, 80);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_left_in_queue"}, exp_q.size(), 0);
      chk({tag, "_protocol_violations"}, viol, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int n;
      // Reset: all outputs quiet while held.
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs_zero",
             int'({in_ready, out_valid, out_pixel, cu_wr_accum, cu_set_avg,
                   cu_clr_accum, cu_intensity, busy, window_done}), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("cycle1_clr_accum", int'(cu_clr_accum), 1);
      chk("cycle1_in_ready", int'(in_ready), 0);
      @(negedge clk);
      chk("cycle2_in_ready", int'(in_ready), 1);
      chk("cycle2_busy", int'(busy), 0);
      chk("cycle2_clr_accum", int'(cu_clr_accum), 0);
      @(posedge clk);
      #1;

      // Flat window of 100: average 100, equal pixels take -32 -> 68.
      load_window(0, 8'd100, 8'd68, 1'b0);
      finish_window("flat", 0);

      // Ramp 0..79.
      load_window(1, 8'd0, 8'd0, 1'b0);
      finish_window("ramp", 0);

      // Same ramp with input bubbles.
      load_window(1, 8'd0, 8'd0, 1'b1);
      finish_window("bubble", 0);

      // Flat 50 -> 18, downstream stalls for 5 cycles after 10 outputs.
      load_window(0, 8'd50, 8'd18, 1'b0);
      finish_window("stall", 10);

      // Reset partway through EMIT of a flat-120 window.
      load_window(0, 8'd120, 8'd88, 1'b0);
      n = 0;
      while (outs_this < 30 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_30_outputs", int'(outs_this >= 30), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_out_pixel", int'(out_pixel), 0);
      chk("abort_in_ready", int'(in_ready), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fresh window of 200 -> 168, no residue from the aborted one.
      load_window(0, 8'd200, 8'd168, 1'b0);
      finish_window("post_reset", 0);
`ifdef BCAU_CTRL_WIN_CNT_EN
      chk("win_count", int'(win_count), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
